friscv_irq_conditioner: RTL and testbench

Conditions one external interrupt line after it has passed through the two-flop bit synchronizer. It glitch-filters the synchronized bit and detects level or edge events per a runtime mode. It latches a pending flag that the CSR/interrupt unit clears with an acknowledge pulse. Overrun (missed events) is flagged, and accepted events are counted for debug.

---
 rtl/friscv_irq_conditioner.sv | 117 +++++++++++
 tb/tb_friscv_irq_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_irq_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : friscv_irq_conditioner
//  Brief    : Glitch filter, level/edge event detector, pending/overrun
//             latch and saturating event counter for one synchronized IRQ.
//  Revision : 1.0
// ============================================================================
module friscv_irq_conditioner #(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             irq_i,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             irq_ack_i,
    output logic             filtered_o,
    output logic             pending_o,
    output logic             missed_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    localparam int              c_CW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(FILTER_CYCLES - 1);
    localparam logic [1:0]      c_MODE_LEVEL = 2'b00;
    localparam logic [1:0]      c_MODE_RISE  = 2'b01;
    localparam logic [1:0]      c_MODE_FALL  = 2'b10;

    logic             r_f;
    logic [c_CW-1:0]  r_c;
    logic             r_pending;
    logic             r_missed;
    logic [CNT_W-1:0] r_cnt;

    logic             w_f_next;
    logic [c_CW-1:0]  w_c_next;
    logic             w_rise;
    logic             w_fall;
    logic             w_evt;
    logic             w_acc;
    logic             w_new;

    // Any sample equal to the filtered state restarts the run of differing samples.
    always_comb begin
        w_f_next = r_f;
        w_c_next = r_c;
        if (irq_i == r_f) begin
            w_c_next = '0;
        end else if (r_c == c_LAST) begin
            w_f_next = irq_i;
            w_c_next = '0;
        end else begin
            w_c_next = r_c + c_CW'(1);
        end
    end

    assign w_rise = ~r_f & w_f_next;
    assign w_fall = r_f & ~w_f_next;

    always_comb begin
        w_evt = 1'b0;
        case (mode)
            c_MODE_LEVEL: w_evt = w_f_next;
            c_MODE_RISE:  w_evt = w_rise;
            c_MODE_FALL:  w_evt = w_fall;
            default:      w_evt = w_rise | w_fall;
        endcase
    end

    assign w_acc = w_evt & en;
    // In level mode only the rising transition is a fresh event for count/overrun.
    assign w_new = (mode == c_MODE_LEVEL) ? (w_rise & en) : w_acc;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_f       <= 1'b0;
            r_c       <= '0;
            r_pending <= 1'b0;
            r_missed  <= 1'b0;
            r_cnt     <= '0;
        end else if (srst) begin
            r_f       <= 1'b0;
            r_c       <= '0;
            r_pending <= 1'b0;
            r_missed  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_f <= w_f_next;
            r_c <= w_c_next;

            if (w_acc) begin
                r_pending <= 1'b1;
            end else if (irq_ack_i) begin
                r_pending <= 1'b0;
            end

            if (w_new && r_pending && !irq_ack_i) begin
                r_missed <= 1'b1;
            end else if (irq_ack_i) begin
                r_missed <= 1'b0;
            end

            if (w_new && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign filtered_o = r_f;
    assign pending_o  = r_pending;
    assign missed_o   = r_missed;
    assign evt_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_friscv_irq_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_friscv_irq_conditioner
//  Brief    : Directed plus randomized self-checking bench with a sample-
//             window reference model; second instance checks CNT_W=2.
//  Revision : 1.0
// ============================================================================
module tb_friscv_irq_conditioner;

    localparam int FC = 4;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       srst;
    logic       irq_i;
    logic       en;
    logic [1:0] mode;
    logic       irq_ack_i;

    logic       f1, p1, m1;
    logic [7:0] c1;
    logic       f2, p2, m2;
    logic [1:0] c2;

    int total_n = 0;
    int bad_n   = 0;

    // Reference model state: last FC samples since reset, and accepted-event total.
    bit mf, mp, mm;
    int mtot;
    bit hist [FC];
    int hist_n;

    always #5 aclk = ~aclk;

    friscv_irq_conditioner #(.FILTER_CYCLES(FC), .CNT_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .irq_i(irq_i), .en(en),
        .mode(mode), .irq_ack_i(irq_ack_i), .filtered_o(f1), .pending_o(p1),
        .missed_o(m1), .evt_cnt_o(c1)
    );

    friscv_irq_conditioner #(.FILTER_CYCLES(FC), .CNT_W(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .irq_i(irq_i), .en(en),
        .mode(mode), .irq_ack_i(irq_ack_i), .filtered_o(f2), .pending_o(p2),
        .missed_o(m2), .evt_cnt_o(c2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mf = 0; mp = 0; mm = 0; mtot = 0; hist_n = 0;
        for (int k = 0; k < FC; k++) hist[k] = 0;
    endtask

    // Filter toggles once the most recent FC samples all disagree with the filtered state.
    task automatic model_edge();
        bit fn, rise, fall, evt, acc, nw, alldiff;
        if (!aresetn || srst) begin
            model_clear();
            return;
        end
        for (int k = FC - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq_i;
        if (hist_n < FC) hist_n++;
        alldiff = (hist_n == FC);
        for (int k = 0; k < FC; k++) if (hist[k] == mf) alldiff = 0;
        fn   = alldiff ? irq_i : mf;
        rise = !mf && fn;
        fall = mf && !fn;
        case (mode)
            2'b00:   evt = fn;
            2'b01:   evt = rise;
            2'b10:   evt = fall;
            default: evt = rise || fall;
        endcase
        acc = evt && en;
        nw  = (mode == 2'b00) ? (rise && en) : acc;
        if (nw && mp && !irq_ack_i) mm = 1;
        else if (irq_ack_i) mm = 0;
        if (acc) mp = 1;
        else if (irq_ack_i) mp = 0;
        if (nw) mtot++;
        mf = fn;
    endtask

    task automatic check_all();
        chk("filtered",  {31'd0, f1}, {31'd0, mf});
        chk("pending",   {31'd0, p1}, {31'd0, mp});
        chk("missed",    {31'd0, m1}, {31'd0, mm});
        chk("evt_cnt",   {24'd0, c1}, (mtot > 255) ? 255 : mtot);
        chk("filtered2", {31'd0, f2}, {31'd0, mf});
        chk("pending2",  {31'd0, p2}, {31'd0, mp});
        chk("missed2",   {31'd0, m2}, {31'd0, mm});
        chk("evt_cnt2",  {30'd0, c2}, (mtot > 3) ? 3 : mtot);
    endtask

    task automatic step();
        @(posedge aclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input bit v, input int n);
        irq_i = v;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic keep_p;
        aresetn = 1'b0; srst = 1'b0; irq_i = 1'b0; en = 1'b1;
        mode = 2'b01; irq_ack_i = 1'b0;
        model_clear();
        step(); step();
        chk("reset_filtered", {31'd0, f1}, 0);
        chk("reset_cnt", {24'd0, c1}, 0);
        aresetn = 1'b1;
        step();

        // Glitch of FC-1 samples must not propagate.
        hold(1, 3);
        hold(0, 1);
        chk("glitch_f", {31'd0, f1}, 0);
        chk("glitch_p", {31'd0, p1}, 0);
        chk("glitch_cnt", {24'd0, c1}, 0);

        // Clean rise: filtered and pending at the same (4th) edge.
        hold(1, 3);
        chk("rise_f_early", {31'd0, f1}, 0);
        hold(1, 1);
        chk("rise_f", {31'd0, f1}, 1);
        chk("rise_p", {31'd0, p1}, 1);
        chk("rise_cnt", {24'd0, c1}, 1);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        chk("ack_p", {31'd0, p1}, 0);

        // Overrun: two rises without ack.
        hold(0, 4); hold(1, 4);
        chk("ovr_p", {31'd0, p1}, 1);
        chk("ovr_m0", {31'd0, m1}, 0);
        hold(0, 4); hold(1, 4);
        chk("ovr_m1", {31'd0, m1}, 1);
        chk("ovr_cnt", {24'd0, c1}, 3);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        chk("ovr_ack_p", {31'd0, p1}, 0);
        chk("ovr_ack_m", {31'd0, m1}, 0);

        // Rise coincident with ack.
        hold(0, 4); hold(1, 3);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        chk("coinc_p", {31'd0, p1}, 1);
        chk("coinc_m", {31'd0, m1}, 0);
        chk("coinc_cnt", {24'd0, c1}, 4);

        // Level mode, line stable high, periodic acks.
        mode = 2'b00;
        for (int i = 0; i < 15; i++) begin
            irq_ack_i = (i % 5 == 4);
            step();
            chk("level_p", {31'd0, p1}, 1);
        end
        irq_ack_i = 1'b0;
        chk("level_cnt", {24'd0, c1}, 4);
        chk("level_m", {31'd0, m1}, 0);

        // Both edges, then a toggle while disabled.
        mode = 2'b11;
        hold(0, 4); hold(1, 4); hold(0, 4);
        chk("both_cnt", {24'd0, c1}, 7);
        chk("sat_cnt2", {30'd0, c2}, 3);
        keep_p = p1;
        en = 1'b0;
        hold(1, 5);
        chk("dis_f", {31'd0, f1}, 1);
        chk("dis_cnt", {24'd0, c1}, 7);
        chk("dis_p", {31'd0, p1}, {31'd0, keep_p});
        en = 1'b1;

        // Async reset mid-filter with pending and missed set.
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        hold(0, 4); hold(1, 4); hold(0, 2);
        chk("pre_rst_p", {31'd0, p1}, 1);
        chk("pre_rst_m", {31'd0, m1}, 1);
        aresetn = 1'b0;
        #1;
        model_clear();
        chk("arst_f", {31'd0, f1}, 0);
        chk("arst_p", {31'd0, p1}, 0);
        chk("arst_m", {31'd0, m1}, 0);
        chk("arst_cnt", {24'd0, c1}, 0);
        step();
        aresetn = 1'b1;

        // Sync reset.
        hold(1, 4);
        chk("pre_srst_p", {31'd0, p1}, 1);
        srst = 1'b1; irq_ack_i = 1'b0; step(); srst = 1'b0;
        chk("srst_f", {31'd0, f1}, 0);
        chk("srst_p", {31'd0, p1}, 0);
        chk("srst_cnt", {24'd0, c1}, 0);

        // Randomized run with bursty line activity.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 15) irq_i = ~irq_i;
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
            en        = ($urandom_range(0, 99) < 85);
            irq_ack_i = ($urandom_range(0, 99) < 10);
            srst      = ($urandom_range(0, 999) < 5);
            step();
        end
        srst = 1'b0;

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
`default_nettype wire
